avl_slv_mch_intf: RTL and testbench
===================================

// Module: avl_slv_mch_intf
// PURPOSE
//  Avalon-MM slave to N-channel microprocessor-interface bridge, successor of the single-channel bridge.
//  Decodes a channel-select field from the Avalon word address and drives one shared up-bus with per-channel enables.
//  Adds byte enables, a parametrised timeout with SLVERR, and DECODEERROR for unmapped channels. One access outstanding.
//  Sits between the Avalon interconnect and multiple register-file/CPU-port clients.
// PARAMETERS
//  AVL_ADDR      32             Avalon address width
//  AVL_DATW      32             Avalon data width (multiple of 8)
//  AVL_BYTEENW   AVL_DATW/8     byte-enable width
//  AVL_ADDRUNIT  "SYMBOL"       "SYMBOL" or "WORD"; SYMBOL drops clog2(AVL_BYTEENW) LSBs
//  N_CH          4              number of up-bus channels, 1..16
//  CH_SEL_LSB    8              bit position of channel field within the word address
//  CH_SEL_W      clog2(N_CH)    channel field width (min 1)
//  TIMEOUT_W     8              timeout counter width; timeout after 2**TIMEOUT_W-1 ACCESS cycles
//  TIMEOUT_D     32'hCAFE_CAFE  read data returned on timeout
//  G_CPUA        derived        up address width = AVL_ADDR - address bit-align
// PORTS
//  clk             in   1              single clock
//  rst             in   1              asynchronous active-high reset
//  aslv_addr       in   AVL_ADDR       Avalon address
//  aslv_wr         in   1              write request
//  aslv_rd         in   1              read request
//  aslv_byteena    in   AVL_BYTEENW    byte enables
//  aslv_wrdat      in   AVL_DATW       write data
//  aslv_rddat      out  AVL_DATW       read data
//  aslv_rddatvld   out  1              read data valid, 1-cycle pulse
//  aslv_wrrespvld  out  1              write response valid, 1-cycle pulse
//  aslv_resp       out  2              00 OKAY, 10 SLVERR, 11 DECODEERROR
//  aslv_waitreq    out  1              Avalon waitrequest
//  upa             out  G_CPUA         shared up address (full word address)
//  upbe            out  AVL_BYTEENW    shared up byte enables
//  updi            out  AVL_DATW       shared up write data
//  upen            out  N_CH           per-channel enable, one-hot or zero
//  upws / uprs     out  1              write/read strobe, 1-cycle pulse
//  updo            in   N_CH*AVL_DATW  per-channel read data, channel k at [k*AVL_DATW +: AVL_DATW]
//  uprdy           in   N_CH           per-channel ready
//  tmo_evt         out  1              1-cycle pulse per timed-out access
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-high. rst forces state IDLE, all outputs and regs to 0 immediately.
//  FSM IDLE -> ACCESS -> RESP -> IDLE; IDLE -> RESP directly on decode miss.
//  IDLE: aslv_waitreq = aslv_wr|aslv_rd (combinational). On edge with request: latch upa, upbe, updi (write only), ch.
//   ch < N_CH: upen[ch]<=1, upws or uprs <=1, go ACCESS. ch >= N_CH: resp<=11, rddat<=0, go RESP, no strobe.
//   wr and rd both high: write taken, read ignored.
//  ACCESS: waitreq=1; strobe high first ACCESS cycle only; upen held; timeout counter increments per cycle.
//   Only uprdy[ch] observed; other channels' uprdy/updo ignored.
//   uprdy[ch]=1: rddat<=updo[ch] (read) or 0 (write), resp<=00, go RESP.
//   counter all-ones and no uprdy: rddat<=TIMEOUT_D (read), resp<=10, tmo_evt pulse, go RESP.
//   uprdy and timeout same cycle: uprdy wins, OKAY.
//  RESP: upen<=0, waitreq=0 (command accepted), rddatvld (read) or wrrespvld (write) high exactly this cycle.
//   aslv_rddat/aslv_resp hold until next RESP; counter cleared.
//  Latency: strobe 1 cycle after request; response 1 cycle after uprdy; min request-to-accept 3 cycles.
//  Master must hold request stable while waitreq=1; new request accepted in IDLE the cycle after RESP.
// STRUCTURE
//  Shared include avl_defs.vh: AVL_RESP_OKAY/SLVERR/DECERR codes, clog2/fclog2 functions, FSM state encodings.
//  Sub-module acc_tmo_cnt (TIMEOUT_W): clear/enable inputs, terminal-count output; rest flat in this module.
// TESTING
//  N_CH=4: read addr 0x0000_0104 (ch1), uprdy[1]=1 next cycle, updo ch1=0x1234_5678 -> rddatvld, rddat 0x12345678, resp 00.
//  Write ch2 data 0xA5A5_A5A5, byteena 4'b0011 -> upen=4'b0100, upws 1 cycle, upbe 0011, updi A5A5A5A5, wrrespvld+resp 00.
//  Read ch3, uprdy never -> after 255 ACCESS cycles rddat CAFECAFE, resp 10, tmo_evt once, upen back to 0.
//  N_CH=3, read ch3 -> no upen/strobe, RESP next cycle, resp 11, rddat 0.
//  Read ch0 with uprdy[1]=1, uprdy[0] at cycle 5 -> only ch0 completes; rst mid-ACCESS -> outputs 0, IDLE.
//  Back-to-back wr ch0 then rd ch1, uprdy same cycle as terminal count -> OKAY, no tmo_evt.

Source files
------------

// File: rtl/avl_slv_mch_intf_pkg.sv
// Shared definitions for the Avalon-MM to multi-channel up-bus bridge:
// response codes, FSM state encodings and width helpers.
package avl_slv_mch_intf_pkg;

    typedef logic [1:0] avl_resp_t;

    localparam avl_resp_t AVL_RESP_OKAY   = 2'b00;
    localparam avl_resp_t AVL_RESP_SLVERR = 2'b10;
    localparam avl_resp_t AVL_RESP_DECERR = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // Channel field needs at least one bit even with a single channel.
    function automatic int fclog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/avl_slv_mch_intf_acc_tmo_cnt.sv
// Access timeout counter: counts ACCESS cycles, flags terminal count at all-ones.
module avl_slv_mch_intf_acc_tmo_cnt #(
    parameter int TIMEOUT_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [TIMEOUT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + TIMEOUT_W'(1);
        end
    end

    assign tc_o = &cnt_q;

endmodule

// File: rtl/avl_slv_mch_intf.sv
// Avalon-MM slave bridging to N up-bus channels sharing address/data/strobes,
// with per-channel enables, access timeout (SLVERR) and decode miss (DECODEERROR).
module avl_slv_mch_intf
    import avl_slv_mch_intf_pkg::*;
#(
    parameter int    AVL_ADDR     = 32,
    parameter int    AVL_DATW     = 32,
    parameter int    AVL_BYTEENW  = AVL_DATW / 8,
    parameter string AVL_ADDRUNIT = "SYMBOL",
    parameter int    N_CH         = 4,
    parameter int    CH_SEL_LSB   = 8,
    parameter int    CH_SEL_W     = fclog2(N_CH),
    parameter int    TIMEOUT_W    = 8,
    parameter logic [AVL_DATW-1:0] TIMEOUT_D = 32'hCAFE_CAFE,
    localparam int   ADDR_ALIGN   = (AVL_ADDRUNIT == "SYMBOL") ? $clog2(AVL_BYTEENW) : 0,
    localparam int   G_CPUA       = AVL_ADDR - ADDR_ALIGN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [AVL_ADDR-1:0]      aslv_addr,
    input  logic                     aslv_wr,
    input  logic                     aslv_rd,
    input  logic [AVL_BYTEENW-1:0]   aslv_byteena,
    input  logic [AVL_DATW-1:0]      aslv_wrdat,
    output logic [AVL_DATW-1:0]      aslv_rddat,
    output logic                     aslv_rddatvld,
    output logic                     aslv_wrrespvld,
    output logic [1:0]               aslv_resp,
    output logic                     aslv_waitreq,
    output logic [G_CPUA-1:0]        upa,
    output logic [AVL_BYTEENW-1:0]   upbe,
    output logic [AVL_DATW-1:0]      updi,
    output logic [N_CH-1:0]          upen,
    output logic                     upws,
    output logic                     uprs,
    input  logic [N_CH*AVL_DATW-1:0] updo,
    input  logic [N_CH-1:0]          uprdy,
    output logic                     tmo_evt
);

    logic [1:0]             state_q, state_d;
    logic [CH_SEL_W-1:0]    ch_q, ch_d;
    logic                   wr_q, wr_d;
    logic [G_CPUA-1:0]      upa_q, upa_d;
    logic [AVL_BYTEENW-1:0] upbe_q, upbe_d;
    logic [AVL_DATW-1:0]    updi_q, updi_d;
    logic [AVL_DATW-1:0]    rddat_q, rddat_d;
    logic [N_CH-1:0]        upen_q, upen_d;
    logic                   upws_q, upws_d, uprs_q, uprs_d;
    logic                   rddatvld_q, rddatvld_d, wrrespvld_q, wrrespvld_d;
    logic                   tmo_q, tmo_d;
    avl_resp_t              resp_q, resp_d;

    logic [G_CPUA-1:0]      word_addr;
    logic [CH_SEL_W-1:0]    ch_in;
    logic [N_CH-1:0]        ch_onehot;
    logic [AVL_DATW-1:0]    do_sel;
    logic                   ch_hit, req, rdy_sel, tmo_tc, cnt_clr, cnt_en;
    logic                   unused_addr;

    assign word_addr   = aslv_addr[AVL_ADDR-1:ADDR_ALIGN];
    assign unused_addr = ^aslv_addr;
    assign ch_in       = word_addr[CH_SEL_LSB +: CH_SEL_W];
    assign ch_hit      = {1'b0, ch_in} < (CH_SEL_W + 1)'(N_CH);
    assign req         = aslv_wr | aslv_rd;

    // Only the latched channel's ready/data are visible to the FSM.
    always_comb begin
        rdy_sel   = 1'b0;
        do_sel    = '0;
        ch_onehot = '0;
        for (int k = 0; k < N_CH; k++) begin
            ch_onehot[k] = (ch_in == CH_SEL_W'(k));
            if (ch_q == CH_SEL_W'(k)) begin
                rdy_sel = uprdy[k];
                do_sel  = updo[k*AVL_DATW +: AVL_DATW];
            end
        end
    end

    // Counting starts on the accepting edge so ACCESS cycle k sees count k.
    assign cnt_en  = ((state_q == ST_IDLE) && req && ch_hit) || (state_q == ST_ACCESS);
    assign cnt_clr = (state_q == ST_RESP);

    avl_slv_mch_intf_acc_tmo_cnt #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_tmo_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .tc_o  (tmo_tc)
    );

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        wr_d        = wr_q;
        upa_d       = upa_q;
        upbe_d      = upbe_q;
        updi_d      = updi_q;
        rddat_d     = rddat_q;
        resp_d      = resp_q;
        upen_d      = upen_q;
        upws_d      = 1'b0;
        uprs_d      = 1'b0;
        rddatvld_d  = 1'b0;
        wrrespvld_d = 1'b0;
        tmo_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    upa_d  = word_addr;
                    upbe_d = aslv_byteena;
                    ch_d   = ch_in;
                    wr_d   = aslv_wr;
                    if (aslv_wr) begin
                        updi_d = aslv_wrdat;
                    end
                    if (ch_hit) begin
                        upen_d  = ch_onehot;
                        upws_d  = aslv_wr;
                        uprs_d  = ~aslv_wr;
                        state_d = ST_ACCESS;
                    end else begin
                        resp_d      = AVL_RESP_DECERR;
                        rddat_d     = '0;
                        rddatvld_d  = ~aslv_wr;
                        wrrespvld_d = aslv_wr;
                        state_d     = ST_RESP;
                    end
                end
            end
            ST_ACCESS: begin
                if (rdy_sel) begin
                    rddat_d     = wr_q ? '0 : do_sel;
                    resp_d      = AVL_RESP_OKAY;
                    rddatvld_d  = ~wr_q;
                    wrrespvld_d = wr_q;
                    state_d     = ST_RESP;
                end else if (tmo_tc) begin
                    rddat_d     = wr_q ? '0 : TIMEOUT_D;
                    resp_d      = AVL_RESP_SLVERR;
                    tmo_d       = 1'b1;
                    rddatvld_d  = ~wr_q;
                    wrrespvld_d = wr_q;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                upen_d  = '0;
                state_d = ST_IDLE;
            end
            default: begin
                upen_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ch_q        <= '0;
            wr_q        <= 1'b0;
            upa_q       <= '0;
            upbe_q      <= '0;
            updi_q      <= '0;
            rddat_q     <= '0;
            resp_q      <= AVL_RESP_OKAY;
            upen_q      <= '0;
            upws_q      <= 1'b0;
            uprs_q      <= 1'b0;
            rddatvld_q  <= 1'b0;
            wrrespvld_q <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            wr_q        <= wr_d;
            upa_q       <= upa_d;
            upbe_q      <= upbe_d;
            updi_q      <= updi_d;
            rddat_q     <= rddat_d;
            resp_q      <= resp_d;
            upen_q      <= upen_d;
            upws_q      <= upws_d;
            uprs_q      <= uprs_d;
            rddatvld_q  <= rddatvld_d;
            wrrespvld_q <= wrrespvld_d;
            tmo_q       <= tmo_d;
        end
    end

    // waitreq is forced low during reset so every output reads 0 under rst.
    assign aslv_waitreq   = ~rst & (((state_q == ST_IDLE) & req) | (state_q == ST_ACCESS));
    assign aslv_rddat     = rddat_q;
    assign aslv_resp      = resp_q;
    assign aslv_rddatvld  = rddatvld_q;
    assign aslv_wrrespvld = wrrespvld_q;
    assign upa            = upa_q;
    assign upbe           = upbe_q;
    assign updi           = updi_q;
    assign upen           = upen_q;
    assign upws           = upws_q;
    assign uprs           = uprs_q;
    assign tmo_evt        = tmo_q;

endmodule

// File: tb/tb_avl_slv_mch_intf.sv
// Directed bench: a 4-channel and a 3-channel bridge, table of accesses plus reset sequences.
module tb_avl_slv_mch_intf;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  aslv_addr;
    logic         aslv_wr, aslv_rd;
    logic [3:0]   aslv_byteena;
    logic [31:0]  aslv_wrdat;
    logic [3:0]   uprdy;
    logic [127:0] updo;
    logic         sel3;

    logic [31:0] rddat4, rddat3, updi4, updi3;
    logic        rdvld4, rdvld3, wrvld4, wrvld3, wreq4, wreq3;
    logic        upws4, upws3, uprs4, uprs3, tmo4, tmo3;
    logic [1:0]  resp4, resp3;
    logic [29:0] upa4, upa3;
    logic [3:0]  upbe4, upbe3, upen4;
    logic [2:0]  upen3;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    avl_slv_mch_intf #(.N_CH(4)) dut4 (
        .clk(clk), .rst(rst), .aslv_addr(aslv_addr), .aslv_wr(aslv_wr & ~sel3),
        .aslv_rd(aslv_rd & ~sel3), .aslv_byteena(aslv_byteena), .aslv_wrdat(aslv_wrdat),
        .aslv_rddat(rddat4), .aslv_rddatvld(rdvld4), .aslv_wrrespvld(wrvld4),
        .aslv_resp(resp4), .aslv_waitreq(wreq4), .upa(upa4), .upbe(upbe4), .updi(updi4),
        .upen(upen4), .upws(upws4), .uprs(uprs4), .updo(updo), .uprdy(uprdy), .tmo_evt(tmo4)
    );

    avl_slv_mch_intf #(.N_CH(3)) dut3 (
        .clk(clk), .rst(rst), .aslv_addr(aslv_addr), .aslv_wr(aslv_wr & sel3),
        .aslv_rd(aslv_rd & sel3), .aslv_byteena(aslv_byteena), .aslv_wrdat(aslv_wrdat),
        .aslv_rddat(rddat3), .aslv_rddatvld(rdvld3), .aslv_wrrespvld(wrvld3),
        .aslv_resp(resp3), .aslv_waitreq(wreq3), .upa(upa3), .upbe(upbe3), .updi(updi3),
        .upen(upen3), .upws(upws3), .uprs(uprs3), .updo(updo[95:0]), .uprdy(uprdy[2:0]),
        .tmo_evt(tmo3)
    );

    wire [31:0] o_rddat  = sel3 ? rddat3 : rddat4;
    wire        o_rdvld  = sel3 ? rdvld3 : rdvld4;
    wire        o_wrvld  = sel3 ? wrvld3 : wrvld4;
    wire [1:0]  o_resp   = sel3 ? resp3 : resp4;
    wire        o_wreq   = sel3 ? wreq3 : wreq4;
    wire [29:0] o_upa    = sel3 ? upa3 : upa4;
    wire [3:0]  o_upbe   = sel3 ? upbe3 : upbe4;
    wire [31:0] o_updi   = sel3 ? updi3 : updi4;
    wire [3:0]  o_upen   = sel3 ? {1'b0, upen3} : upen4;
    wire        o_upws   = sel3 ? upws3 : upws4;
    wire        o_uprs   = sel3 ? uprs3 : uprs4;
    wire        o_tmo    = sel3 ? tmo3 : tmo4;

    typedef struct {
        logic        sel3;
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rdata;
        logic [3:0]  noise;
        logic [3:0]  exp_upen;
        logic [29:0] exp_upa;
        int          exp_strb;
        int          exp_lat;
        logic [31:0] exp_rddat;
        logic [1:0]  exp_resp;
        int          exp_tmo;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_acc(input int idx, input vec_t v);
        int          c, k, strobes, tmo_cnt, lat, ch;
        logic        done, ws_seen, wait_bad, onehot_bad, rdvld_s, wrvld_s, wreq_end;
        logic [3:0]  upen_s, upbe_s;
        logic [29:0] upa_s;
        logic [31:0] updi_s, rddat_s;
        logic [1:0]  resp_s;
        string       p;
        p = $sformatf("v%0d_", idx);
        c = 0; k = -1; strobes = 0; tmo_cnt = 0; lat = 0;
        done = 0; ws_seen = 0; wait_bad = 0; onehot_bad = 0;
        rdvld_s = 0; wrvld_s = 0; wreq_end = 1;
        upen_s = '0; upbe_s = '0; upa_s = '0; updi_s = '0; rddat_s = '0; resp_s = '0;
        ch = int'(v.addr[11:10]);

        @(negedge clk);
        check({p, "idle_upen"}, 32'(o_upen), 32'h0);
        sel3 = v.sel3;
        for (int i = 0; i < 4; i++) begin
            updo[i*32 +: 32] = (i == ch) ? v.rdata : (32'hDEAD_0000 | 32'(i));
        end
        uprdy        = v.noise;
        aslv_addr    = v.addr;
        aslv_byteena = v.be;
        aslv_wrdat   = v.wdata;
        aslv_wr      = v.wr;
        aslv_rd      = v.rd;
        #1;
        check({p, "waitreq_idle"}, 32'(o_wreq), 32'h1);

        while (!done && c < 400) begin
            @(negedge clk);
            c++;
            if (o_upws | o_uprs) begin
                strobes++;
                k       = 0;
                ws_seen = o_upws;
                upen_s  = o_upen;
                upa_s   = o_upa;
                upbe_s  = o_upbe;
                updi_s  = o_updi;
            end else if (k >= 0) begin
                k++;
            end
            if (o_upen != 4'h0 && !$onehot(o_upen)) onehot_bad = 1;
            if (o_tmo) tmo_cnt++;
            if (o_rdvld | o_wrvld) begin
                done     = 1;
                lat      = c;
                rddat_s  = o_rddat;
                resp_s   = o_resp;
                rdvld_s  = o_rdvld;
                wrvld_s  = o_wrvld;
                wreq_end = o_wreq;
                aslv_wr  = 0;
                aslv_rd  = 0;
                uprdy    = '0;
            end else begin
                if (!o_wreq) wait_bad = 1;
                uprdy = v.noise;
                if (k >= 0 && k >= v.delay) uprdy[ch] = 1'b1;
            end
        end
        aslv_wr = 0;
        aslv_rd = 0;
        uprdy   = '0;

        check({p, "completed"}, 32'(done), 32'h1);
        check({p, "latency"}, 32'(lat), 32'(v.exp_lat));
        check({p, "strobes"}, 32'(strobes), 32'(v.exp_strb));
        if (strobes > 0) begin
            check({p, "upen"}, 32'(upen_s), 32'(v.exp_upen));
            check({p, "upa"}, 32'(upa_s), 32'(v.exp_upa));
            check({p, "upbe"}, 32'(upbe_s), 32'(v.be));
            check({p, "strobe_is_ws"}, 32'(ws_seen), 32'(v.wr));
            if (v.wr) check({p, "updi"}, updi_s, v.wdata);
        end
        check({p, "rddat"}, rddat_s, v.exp_rddat);
        check({p, "resp"}, 32'(resp_s), 32'(v.exp_resp));
        check({p, "rddatvld"}, 32'(rdvld_s), 32'(!v.wr));
        check({p, "wrrespvld"}, 32'(wrvld_s), 32'(v.wr));
        check({p, "waitreq_resp"}, 32'(wreq_end), 32'h0);
        check({p, "waitreq_held"}, 32'(wait_bad), 32'h0);
        check({p, "upen_onehot"}, 32'(onehot_bad), 32'h0);
        check({p, "tmo_evt_cnt"}, 32'(tmo_cnt), 32'(v.exp_tmo));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            sel3 wr rd addr          be      wdata          dly   rdata          noise   upen    upa      strb lat  rddat          resp   tmo
        vecs[0] = '{1'b0,1'b0,1'b1,32'h0000_0410,4'hF,   32'h0,         0,    32'h1234_5678, 4'b0000,4'b0010,30'h104, 1, 2,   32'h1234_5678, 2'b00, 0};
        vecs[1] = '{1'b0,1'b1,1'b0,32'h0000_0840,4'b0011,32'hA5A5_A5A5, 0,    32'h0,         4'b0000,4'b0100,30'h210, 1, 2,   32'h0,         2'b00, 0};
        vecs[2] = '{1'b0,1'b0,1'b1,32'h0000_0FF0,4'hF,   32'h0,         1000, 32'h5555_AAAA, 4'b0111,4'b1000,30'h3FC, 1, 256, 32'hCAFE_CAFE, 2'b10, 1};
        vecs[3] = '{1'b0,1'b0,1'b1,32'h0000_0020,4'hF,   32'h0,         4,    32'h0BAD_F00D, 4'b0010,4'b0001,30'h008, 1, 6,   32'h0BAD_F00D, 2'b00, 0};
        vecs[4] = '{1'b0,1'b1,1'b0,32'h0000_0004,4'b1100,32'h0102_0304, 1,    32'h0,         4'b0000,4'b0001,30'h001, 1, 3,   32'h0,         2'b00, 0};
        vecs[5] = '{1'b0,1'b0,1'b1,32'h0000_07FC,4'hF,   32'h0,         254,  32'h7777_1111, 4'b0000,4'b0010,30'h1FF, 1, 256, 32'h7777_1111, 2'b00, 0};
        vecs[6] = '{1'b0,1'b1,1'b1,32'h0000_0400,4'b0101,32'hFEED_BEEF, 0,    32'h9999_9999, 4'b0000,4'b0010,30'h100, 1, 2,   32'h0,         2'b00, 0};
        vecs[7] = '{1'b1,1'b0,1'b1,32'h0000_0C00,4'hF,   32'h0,         0,    32'h3333_3333, 4'b0000,4'b0000,30'h0,   0, 1,   32'h0,         2'b11, 0};
        vecs[8] = '{1'b1,1'b0,1'b1,32'h0000_0800,4'hF,   32'h0,         0,    32'h4444_4444, 4'b0000,4'b0100,30'h200, 1, 2,   32'h4444_4444, 2'b00, 0};

        aslv_addr = '0; aslv_wr = 0; aslv_rd = 0; aslv_byteena = '0; aslv_wrdat = '0;
        uprdy = '0; updo = '0; sel3 = 0;

        repeat (3) @(negedge clk);
        check("rst_waitreq", 32'(wreq4), 32'h0);
        check("rst_upen", 32'(upen4), 32'h0);
        check("rst_rddat", rddat4, 32'h0);
        check("rst_resp", 32'(resp4), 32'h0);
        check("rst_rddatvld", 32'(rdvld4), 32'h0);
        check("rst_tmo_evt", 32'(tmo4), 32'h0);
        check("rst_upa", 32'(upa4), 32'h0);
        rst = 0;

        for (int i = 0; i < 9; i++) begin
            run_acc(i, vecs[i]);
        end
        run_acc(9, vecs[0]);

        // Asynchronous reset in the middle of an access.
        @(negedge clk);
        sel3 = 0;
        aslv_addr = 32'h0000_0800;
        aslv_rd   = 1;
        uprdy     = '0;
        repeat (5) @(negedge clk);
        check("mid_upen_active", 32'(upen4), 32'h4);
        check("mid_waitreq_active", 32'(wreq4), 32'h1);
        rst = 1;
        #1;
        check("mid_rst_upen", 32'(upen4), 32'h0);
        check("mid_rst_waitreq", 32'(wreq4), 32'h0);
        check("mid_rst_rddat", rddat4, 32'h0);
        check("mid_rst_updi", updi4, 32'h0);
        check("mid_rst_upa", 32'(upa4), 32'h0);
        aslv_rd = 0;
        @(negedge clk);
        rst = 0;
        run_acc(10, vecs[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
